// File: rtl/wb_retire_stage.sv
// Writeback/retire stage: a QDEPTH-entry FIFO from MEM that retires the head in order.
// Optional macro WB_TRACE_EN adds debug_wb_* trace outputs driven from the head entry.
module wb_retire_stage #(
    parameter int                 QDEPTH    = 2,
    parameter int                 EXC_W     = 12,
    parameter logic [EXC_W*6-1:0] ECODE_MAP = '0,
    parameter logic [EXC_W*9-1:0] ESUB_MAP  = '0
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             ms_to_ws_valid,
    output logic             ws_allowin,
    input  logic [31:0]      ms_pc,
    input  logic [31:0]      ms_vaddr,
    input  logic             ms_rf_we,
    input  logic [4:0]       ms_rf_waddr,
    input  logic [31:0]      ms_rf_wdata,
    input  logic             ms_csr_re,
    input  logic             ms_csr_we,
    input  logic [13:0]      ms_csr_num,
    input  logic [31:0]      ms_csr_wmask,
    input  logic [31:0]      ms_csr_wvalue,
    input  logic             ms_ertn,
    input  logic             ms_refetch,
    input  logic [EXC_W-1:0] ms_exc,
    input  logic             rf_port_busy,
    input  logic [31:0]      csr_rvalue,
    output logic [13:0]      csr_num,
    output logic             csr_we,
    output logic [31:0]      csr_wmask,
    output logic [31:0]      csr_wvalue,
    output logic             rf_we,
    output logic [4:0]       rf_waddr,
    output logic [31:0]      rf_wdata,
    output logic             wb_ex,
    output logic             ertn_flush,
    output logic             refetch_flush,
    output logic [31:0]      wb_pc,
    output logic [31:0]      wb_vaddr,
    output logic [5:0]       wb_ecode,
    output logic [8:0]       wb_esubcode,
    output logic [63:0]      instret
`ifdef WB_TRACE_EN
    ,
    output logic [31:0]      debug_wb_pc,
    output logic [3:0]       debug_wb_rf_we,
    output logic [4:0]       debug_wb_rf_wnum,
    output logic [31:0]      debug_wb_rf_wdata
`endif
);
    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(QDEPTH);

    typedef struct packed {
        logic [31:0]      pc;
        logic [31:0]      vaddr;
        logic             rf_we;
        logic [4:0]       rf_waddr;
        logic [31:0]      rf_wdata;
        logic             csr_re;
        logic             csr_we;
        logic [13:0]      csr_num;
        logic [31:0]      csr_wmask;
        logic [31:0]      csr_wvalue;
        logic             ertn;
        logic             refetch;
        logic [EXC_W-1:0] exc;
    } entry_t;

    entry_t          q [QDEPTH];
    entry_t          head;
    logic [PW-1:0]   rd_ptr, wr_ptr;
    logic [CW-1:0]   count;
    logic            head_valid, head_exc, retire, flush, enq;

    assign head       = q[rd_ptr];
    // Gating with resetn keeps every strobe and data output quiet during the reset cycle.
    assign head_valid = resetn & (count != '0);
    assign head_exc   = |head.exc;
    assign retire     = head_valid & (head_exc | ~head.rf_we | ~rf_port_busy);

    assign wb_ex         = retire & head_exc;
    assign ertn_flush    = retire & head.ertn & ~head_exc;
    assign refetch_flush = retire & head.refetch & ~head_exc & ~head.ertn;
    assign flush         = wb_ex | ertn_flush | refetch_flush;

    assign ws_allowin = (count < DEPTH_C) & ~flush;
    assign enq        = ms_to_ws_valid & ws_allowin;

    assign rf_we      = retire & head.rf_we & ~head_exc;
    assign csr_we     = retire & head.csr_we & ~head_exc;
    assign rf_waddr   = head_valid ? head.rf_waddr : '0;
    assign rf_wdata   = !head_valid ? '0 : (head.csr_re ? csr_rvalue : head.rf_wdata);
    assign csr_num    = head_valid ? head.csr_num : '0;
    assign csr_wmask  = head_valid ? head.csr_wmask : '0;
    assign csr_wvalue = head_valid ? head.csr_wvalue : '0;
    assign wb_pc      = head_valid ? head.pc : '0;
    assign wb_vaddr   = head_valid ? head.vaddr : '0;

    // Walk from the top so the lowest set index (highest priority) wins.
    always_comb begin
        wb_ecode    = '0;
        wb_esubcode = '0;
        for (int i = EXC_W - 1; i >= 0; i--) begin
            if (head.exc[i]) begin
                wb_ecode    = ECODE_MAP[6*i +: 6];
                wb_esubcode = ESUB_MAP[9*i +: 9];
            end
        end
        if (!head_valid) begin
            wb_ecode    = '0;
            wb_esubcode = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            q[wr_ptr] <= '{pc: ms_pc, vaddr: ms_vaddr, rf_we: ms_rf_we,
                           rf_waddr: ms_rf_waddr, rf_wdata: ms_rf_wdata,
                           csr_re: ms_csr_re, csr_we: ms_csr_we, csr_num: ms_csr_num,
                           csr_wmask: ms_csr_wmask, csr_wvalue: ms_csr_wvalue,
                           ertn: ms_ertn, refetch: ms_refetch, exc: ms_exc};
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq)    wr_ptr <= wr_ptr + 1'b1;
            if (retire) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(enq) - CW'(retire);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn)                instret <= '0;
        else if (retire & ~head_exc) instret <= instret + 64'd1;
    end

`ifdef WB_TRACE_EN
    assign debug_wb_pc       = wb_pc;
    assign debug_wb_rf_we    = {4{rf_we}};
    assign debug_wb_rf_wnum  = rf_waddr;
    assign debug_wb_rf_wdata = rf_wdata;
`endif
endmodule

// File: tb/tb_wb_retire_stage.sv
// Directed bench for wb_retire_stage (QDEPTH=2): retire, stall, exception, CSR, ertn/refetch, reset.
module tb_wb_retire_stage;
    localparam int EXC_W = 12;
    localparam logic [EXC_W*6-1:0] ECODE_MAP = (72'h08 << 18) | (72'h21 << 42);
    localparam logic [EXC_W*9-1:0] ESUB_MAP  = (108'h003 << 27) | (108'h005 << 63);

    logic clk = 1'b0, resetn;
    logic ms_to_ws_valid, ws_allowin;
    logic [31:0] ms_pc, ms_vaddr, ms_rf_wdata, ms_csr_wmask, ms_csr_wvalue;
    logic ms_rf_we, ms_csr_re, ms_csr_we, ms_ertn, ms_refetch;
    logic [4:0] ms_rf_waddr;
    logic [13:0] ms_csr_num;
    logic [EXC_W-1:0] ms_exc;
    logic rf_port_busy;
    logic [31:0] csr_rvalue;
    logic [13:0] csr_num;
    logic csr_we, rf_we, wb_ex, ertn_flush, refetch_flush;
    logic [31:0] csr_wmask, csr_wvalue, rf_wdata, wb_pc, wb_vaddr;
    logic [4:0] rf_waddr;
    logic [5:0] wb_ecode;
    logic [8:0] wb_esubcode;
    logic [63:0] instret;

    int n_checks = 0;
    int n_errors = 0;

    wb_retire_stage #(.QDEPTH(2), .EXC_W(EXC_W), .ECODE_MAP(ECODE_MAP), .ESUB_MAP(ESUB_MAP)) dut (
        .clk(clk), .resetn(resetn), .ms_to_ws_valid(ms_to_ws_valid), .ws_allowin(ws_allowin),
        .ms_pc(ms_pc), .ms_vaddr(ms_vaddr), .ms_rf_we(ms_rf_we), .ms_rf_waddr(ms_rf_waddr),
        .ms_rf_wdata(ms_rf_wdata), .ms_csr_re(ms_csr_re), .ms_csr_we(ms_csr_we),
        .ms_csr_num(ms_csr_num), .ms_csr_wmask(ms_csr_wmask), .ms_csr_wvalue(ms_csr_wvalue),
        .ms_ertn(ms_ertn), .ms_refetch(ms_refetch), .ms_exc(ms_exc),
        .rf_port_busy(rf_port_busy), .csr_rvalue(csr_rvalue), .csr_num(csr_num),
        .csr_we(csr_we), .csr_wmask(csr_wmask), .csr_wvalue(csr_wvalue), .rf_we(rf_we),
        .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .wb_ex(wb_ex), .ertn_flush(ertn_flush),
        .refetch_flush(refetch_flush), .wb_pc(wb_pc), .wb_vaddr(wb_vaddr),
        .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode), .instret(instret)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ms_to_ws_valid = 1'b0; ms_pc = '0; ms_vaddr = '0; ms_rf_we = 1'b0;
        ms_rf_waddr = '0; ms_rf_wdata = '0; ms_csr_re = 1'b0; ms_csr_we = 1'b0;
        ms_csr_num = '0; ms_csr_wmask = '0; ms_csr_wvalue = '0; ms_ertn = 1'b0;
        ms_refetch = 1'b0; ms_exc = '0;
    endtask

    task automatic push(input logic [31:0] pc, input logic we, input logic [4:0] wa,
                        input logic [31:0] wd);
        idle();
        ms_to_ws_valid = 1'b1; ms_pc = pc; ms_rf_we = we; ms_rf_waddr = wa; ms_rf_wdata = wd;
    endtask

    initial begin
        idle();
        resetn = 1'b0; rf_port_busy = 1'b0; csr_rvalue = '0;
        tick(); tick();
        resetn = 1'b1;
        #1;
        chk("rst_allowin", ws_allowin, 1);
        chk("rst_rf_we", rf_we, 0);
        chk("rst_wb_pc", wb_pc, 0);
        chk("rst_instret", instret, 0);
        chk("rst_wb_ex", wb_ex, 0);

        // Basic single retire
        push(32'h1c000000, 1, 4, 32'h55);
        #1 chk("t1_allowin", ws_allowin, 1);
        tick(); idle(); #1;
        chk("t1_rf_we", rf_we, 1);
        chk("t1_waddr", rf_waddr, 4);
        chk("t1_wdata", rf_wdata, 32'h55);
        chk("t1_pc", wb_pc, 32'h1c000000);
        tick(); #1;
        chk("t1_instret", instret, 1);
        chk("t1_rf_we_off", rf_we, 0);

        // Fill under busy write port, then drain in order
        rf_port_busy = 1'b1;
        push(32'h100, 1, 1, 32'h11); tick();
        push(32'h104, 1, 2, 32'h22); tick();
        idle(); #1;
        chk("t2_full_allowin", ws_allowin, 0);
        chk("t2_stall_rf_we", rf_we, 0);
        chk("t2_head_pc", wb_pc, 32'h100);
        tick(); #1;
        chk("t2_stable_pc", wb_pc, 32'h100);
        chk("t2_stable_wdata", rf_wdata, 32'h11);
        rf_port_busy = 1'b0; #1;
        chk("t2_r0_we", rf_we, 1);
        chk("t2_r0_waddr", rf_waddr, 1);
        chk("t2_r0_allowin", ws_allowin, 0);
        tick(); #1;
        chk("t2_r1_we", rf_we, 1);
        chk("t2_r1_waddr", rf_waddr, 2);
        chk("t2_r1_wdata", rf_wdata, 32'h22);
        chk("t2_r1_allowin", ws_allowin, 1);
        tick(); #1;
        chk("t2_empty_we", rf_we, 0);
        chk("t2_instret", instret, 3);

        // Exception behind a stalled head; a new MEM instruction is refused
        rf_port_busy = 1'b1;
        push(32'h200, 1, 3, 32'h33); tick();
        push(32'h204, 1, 6, 32'h44);
        ms_csr_we = 1'b1; ms_csr_num = 14'h7; ms_exc = 12'h088; ms_vaddr = 32'hdead0000;
        tick();
        push(32'h208, 1, 5, 32'h77);
        rf_port_busy = 1'b0; #1;
        chk("t3_n0_we", rf_we, 1);
        chk("t3_n0_waddr", rf_waddr, 3);
        chk("t3_n0_allowin", ws_allowin, 0);
        tick(); #1;
        chk("t3_wb_ex", wb_ex, 1);
        chk("t3_ecode", wb_ecode, 6'h08);
        chk("t3_esub", wb_esubcode, 9'h003);
        chk("t3_rf_we", rf_we, 0);
        chk("t3_csr_we", csr_we, 0);
        chk("t3_vaddr", wb_vaddr, 32'hdead0000);
        chk("t3_pc", wb_pc, 32'h204);
        chk("t3_allowin", ws_allowin, 0);
        tick(); idle(); #1;
        chk("t3_ex_off", wb_ex, 0);
        chk("t3_drop_we", rf_we, 0);
        chk("t3_drop_pc", wb_pc, 0);
        chk("t3_allowin_back", ws_allowin, 1);
        chk("t3_instret", instret, 4);

        // CSR read data path, CSR write suppressed by exception, plain CSR write
        push(32'h300, 1, 7, 32'h999);
        ms_csr_re = 1'b1; ms_csr_num = 14'h0005;
        tick(); idle();
        csr_rvalue = 32'hABCD; #1;
        chk("t4_csr_re_we", rf_we, 1);
        chk("t4_csr_re_data", rf_wdata, 32'hABCD);
        chk("t4_csr_num", csr_num, 14'h5);
        chk("t4_csr_we_off", csr_we, 0);
        tick();
        push(32'h304, 0, 0, 0);
        ms_csr_we = 1'b1; ms_csr_num = 14'h10; ms_csr_wmask = 32'hffffffff;
        ms_csr_wvalue = 32'h1234; ms_exc = 12'h080;
        tick(); idle(); #1;
        chk("t4_exc_wb_ex", wb_ex, 1);
        chk("t4_exc_csr_we", csr_we, 0);
        chk("t4_exc_csr_num", csr_num, 14'h10);
        chk("t4_exc_ecode", wb_ecode, 6'h21);
        chk("t4_exc_esub", wb_esubcode, 9'h005);
        tick();
        push(32'h308, 0, 0, 0);
        ms_csr_we = 1'b1; ms_csr_num = 14'h11; ms_csr_wmask = 32'h0f0f0f0f; ms_csr_wvalue = 32'h5678;
        tick(); idle(); #1;
        chk("t4_csr_we", csr_we, 1);
        chk("t4_csr_wvalue", csr_wvalue, 32'h5678);
        chk("t4_csr_wmask", csr_wmask, 32'h0f0f0f0f);
        chk("t4_no_ex", wb_ex, 0);
        tick(); #1;
        chk("t4_instret", instret, 6);

        // ertn with a queued follower and a refused MEM instruction
        rf_port_busy = 1'b1;
        push(32'h400, 1, 9, 32'h1); ms_ertn = 1'b1; tick();
        push(32'h404, 1, 10, 32'h2); tick();
        push(32'h408, 1, 11, 32'h3);
        rf_port_busy = 1'b0; #1;
        chk("t5_ertn", ertn_flush, 1);
        chk("t5_ertn_we", rf_we, 1);
        chk("t5_ertn_allowin", ws_allowin, 0);
        chk("t5_no_ex", wb_ex, 0);
        tick(); idle(); #1;
        chk("t5_ertn_off", ertn_flush, 0);
        chk("t5_drop_pc", wb_pc, 0);
        chk("t5_drop_we", rf_we, 0);
        chk("t5_allowin", ws_allowin, 1);
        chk("t5_instret", instret, 7);
        push(32'h500, 0, 0, 0); ms_ertn = 1'b1; ms_refetch = 1'b1;
        tick(); idle(); #1;
        chk("t5_both_ertn", ertn_flush, 1);
        chk("t5_both_refetch", refetch_flush, 0);
        tick();
        push(32'h504, 0, 0, 0); ms_refetch = 1'b1;
        tick(); idle(); #1;
        chk("t5_refetch", refetch_flush, 1);
        chk("t5_refetch_ertn", ertn_flush, 0);
        tick(); #1;
        chk("t5_refetch_off", refetch_flush, 0);
        chk("t5_instret2", instret, 9);

        // Reset with two entries queued
        rf_port_busy = 1'b1;
        push(32'h600, 1, 12, 32'h6); tick();
        push(32'h604, 1, 13, 32'h7); tick();
        idle();
        rf_port_busy = 1'b0; resetn = 1'b0; #1;
        chk("t6_rst_cycle_we", rf_we, 0);
        chk("t6_rst_cycle_pc", wb_pc, 0);
        tick();
        resetn = 1'b1; #1;
        chk("t6_instret", instret, 0);
        chk("t6_rf_we", rf_we, 0);
        chk("t6_pc", wb_pc, 0);
        chk("t6_allowin", ws_allowin, 1);
        tick(); #1;
        chk("t6_empty_we", rf_we, 0);
        chk("t6_empty_pc", wb_pc, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/wb_retire_stage.md
Name: wb_retire_stage

Overview:
Parametrised writeback/retire stage, successor to the single-entry WB stage. Buffers up to QDEPTH instructions from MEM in a FIFO and retires the head in order: register-file write, CSR read/write, exception/ertn/refetch flush. Exception cause comes from a generic EXC_W-bit vector with parameter-mapped ecode/esubcode priority. Also maintains a 64-bit retired-instruction counter.

Parameters:
QDEPTH, 2, FIFO entries (power of 2, >=2)
EXC_W, 12, exception vector width; bit 0 = highest priority
ECODE_MAP, 0, EXC_W*6-bit packed; bits [6i+5:6i] = ecode for exception bit i
ESUB_MAP, 0, EXC_W*9-bit packed; bits [9i+8:9i] = esubcode for exception bit i

Ports:
clk  in  1  clock
resetn  in  1  synchronous active-low reset
ms_to_ws_valid  in  1  MEM has an instruction
ws_allowin  out  1  stage accepts this cycle
ms_pc  in  32  instruction PC
ms_vaddr  in  32  bad/virtual address for exceptions
ms_rf_we  in  1  writes GPR
ms_rf_waddr  in  5  GPR index
ms_rf_wdata  in  32  GPR data
ms_csr_re  in  1  GPR data comes from CSR read
ms_csr_we  in  1  CSR write
ms_csr_num  in  14  CSR index
ms_csr_wmask  in  32  CSR write mask
ms_csr_wvalue  in  32  CSR write value
ms_ertn  in  1  ertn instruction
ms_refetch  in  1  refetch-after-retire flag
ms_exc  in  EXC_W  exception vector
rf_port_busy  in  1  GPR write port taken this cycle
csr_rvalue  in  32  CSR read data (combinational)
csr_num  out  14  head CSR index
csr_we  out  1  CSR write strobe
csr_wmask  out  32  head mask
csr_wvalue  out  32  head value
rf_we  out  1  GPR write strobe
rf_waddr  out  5  GPR index
rf_wdata  out  32  GPR data
wb_ex  out  1  exception retire pulse
ertn_flush  out  1  ertn retire pulse
refetch_flush  out  1  refetch retire pulse
wb_pc  out  32  head PC
wb_vaddr  out  32  head vaddr
wb_ecode  out  6  ecode of highest-priority set bit
wb_esubcode  out  9  matching esubcode
instret  out  64  retired instruction count

Behaviour:
- Reset: FIFO empty, count=0, instret=0; all strobes 0; all data outputs 0 while empty.
- ws_allowin = (count < QDEPTH) & ~flush, flush = wb_ex|ertn_flush|refetch_flush. Uses registered count only; no enqueue-on-full even if head retires.
- Enqueue on ms_to_ws_valid & ws_allowin; entry visible at head no earlier than next cycle (latency >=1).
- head_exc = |head.exc. retire = head_valid & (head_exc | ~head.rf_we | ~rf_port_busy). Stall holds head; outputs stable.
- rf_we = retire & head.rf_we & ~head_exc; rf_wdata = head.csr_re ? csr_rvalue : head.rf_wdata.
- csr_we = retire & head.csr_we & ~head_exc. csr_num/wmask/wvalue driven from head whenever valid.
- wb_ex = retire & head_exc; ertn_flush = retire & head.ertn & ~head_exc; refetch_flush = retire & head.refetch & ~head_exc & ~head.ertn.
- wb_ecode/esubcode: lowest set index i of head.exc → ECODE_MAP/ESUB_MAP slot i; 0 when none.
- Flush: at the edge, FIFO cleared (all entries, including any younger), count=0; no enqueue that cycle.
- Pointers wrap modulo QDEPTH; count width clog2(QDEPTH)+1.
- instret += 1 on every retire without exception (ertn/refetch count); wraps at 2^64.
- Reset mid-operation discards all entries; no strobes in reset cycle.

Optional Feature:
WB_TRACE_EN: adds outputs debug_wb_pc[31:0], debug_wb_rf_we[3:0] = {4{rf_we}}, debug_wb_rf_wnum[4:0], debug_wb_rf_wdata[31:0], driven from head. Without the macro these ports do not exist; behaviour otherwise identical.

Test Plan:
- Push PC 0x1c000000 rf_we=1 waddr=4 wdata=0x55 → next cycle rf_we=1, waddr 4, data 0x55; instret=1.
- Fill QDEPTH=2 with rf_port_busy=1 → ws_allowin=0 while count=2; release busy → in-order retire over two cycles, allowin returns.
- Head ms_exc=bit3|bit7, ECODE_MAP slot3=0x08 → wb_ex pulse one cycle, ecode 0x08, rf_we=0, csr_we=0, younger entry flushed, count=0, instret unchanged.
- csr_re=1, csr_num=0x0005, csr_rvalue=0xABCD → rf_wdata=0xABCD; csr_we=1 entry with exception → csr_we stays 0.
- ertn entry followed by valid entry → ertn_flush pulse, follower dropped, ms input that cycle not accepted (allowin=0).
- Reset asserted with 2 entries queued → next cycle count=0, instret=0, all strobes 0.
